des_round_sequencer: RTL and testbench
======================================

// Module: des_round_sequencer
// PURPOSE
//   Iterative controller for the DES round datapath. It time-multiplexes one `round` instance
//   over ROUNDS clock cycles and replaces the 16-deep combinational round chain.
//   Sits between the initial permutation and the final permutation. It accepts a post-IP block
//   and its round keys over a valid/ready handshake, then returns the swapped pre-FP block.
//   Supports encrypt and decrypt by selecting the key order.
// PARAMETERS
//   ROUNDS   16   number of Feistel rounds applied per block; the round counter is $clog2(ROUNDS) bits
// PORTS
//   clk              in   1            single clock; all state updates on posedge
//   rst              in   1            synchronous, active-high reset
//   in_valid         in   1            block/keys/decrypt presented
//   in_ready         out  1            sequencer can accept a block (IDLE)
//   init_perm_text   in   64           post-initial-permutation block
//   round_keys       in   [0:ROUNDS-1][47:0]  round keys; key 0 is the most-significant 48 bits
//   decrypt          in   1            1 = apply keys ROUNDS-1..0; 0 = apply keys 0..ROUNDS-1
//   out_valid        out  1            result held on text_final_perm
//   out_ready        in   1            downstream consumes result
//   text_final_perm  out  64           {R_last, L_last}, sent to the final permutation
//   busy             out  1            1 in RUN or DONE
//   round_idx        out  $clog2(ROUNDS)  current round number, 0..ROUNDS-1 (debug)
// BEHAVIOUR
//   - Reset (rst=1 at posedge):
//       state=IDLE, in_ready=1, out_valid=0, busy=0, round_idx=0, data reg=0, text_final_perm=0.
//       Reset aborts any block in flight; its result is never presented.
//   - States: IDLE -> RUN -> DONE -> IDLE.
//   - IDLE:
//       in_ready=1. On in_valid&&in_ready: capture init_perm_text into data reg, all round_keys
//       into key reg, and decrypt into mode reg. Set round_idx=0 and go to RUN.
//       Inputs may change after the accept cycle.
//   - RUN:
//       in_ready=0. Each cycle: data reg <= round(data reg, key[k]), where
//       k = mode ? ROUNDS-1-round_idx : round_idx. round_idx increments by 1.
//       When round_idx==ROUNDS-1, the update still applies, then round_idx wraps to 0 and the
//       state goes to DONE.
//   - DONE:
//       out_valid=1. text_final_perm = {data[31:0], data[63:32]} (halves swapped), held stable.
//       On out_valid&&out_ready: go to IDLE and clear out_valid on the next cycle.
//       Backpressure (out_ready=0) holds DONE and the output indefinitely.
//   - Latency: accept at edge T gives out_valid=1 after edge T+ROUNDS.
//       Throughput is 1 block per ROUNDS+2 cycles minimum (accept, ROUNDS rounds, handoff).
//       No overlap: in_ready=0 through RUN and DONE.
//   - in_valid while not in_ready is ignored; the upstream block holds its data.
//   - out_ready while out_valid=0 has no effect.
//   - Simultaneous rst with any handshake: rst wins.
//   - round_idx is meaningful only in RUN and reads 0 otherwise.
//   - Datapath: pure 64-bit Feistel. No arithmetic widening. The counter compares against
//     ROUNDS-1 exactly and never exceeds it.
// TESTING
//   1. Known-answer encrypt: key 133457799BBCDFF1, plaintext 0123456789ABCDEF through the
//      external IP. Output after FP = 85E813540F0AB405; out_valid rises exactly 16 cycles after accept.
//   2. Decrypt: same keys, decrypt=1, IP(85E813540F0AB405) in -> FP(output) = 0123456789ABCDEF.
//   3. Backpressure: hold out_ready=0 for 10 cycles in DONE. Output and out_valid stay constant;
//      in_ready=0 throughout; the block completes when out_ready=1.
//   4. Input isolation: change init_perm_text, round_keys and decrypt to random values every cycle
//      after accept. The result still matches the golden 16-round combinational model for the
//      captured values.
//   5. Reset mid-run: assert rst at round 7 for 1 cycle. Next cycle: IDLE, in_ready=1,
//      out_valid=0, round_idx=0. A new block then completes correctly.
//   6. Back-to-back: 100 random blocks with random encrypt/decrypt and out_ready always 1.
//      Each block matches the golden model; accepts are spaced exactly 18 cycles apart.

Source files
------------

// File: rtl/des_round_sequencer.sv
// Iterative DES round controller: one Feistel round per clock over ROUNDS cycles.
// Ports: clk/rst, in_valid/in_ready + block/keys/decrypt in, out_valid/out_ready + swapped block out, busy, round_idx.
module des_round_sequencer #(
  parameter int ROUNDS = 16
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [63:0]                init_perm_text,
  input  logic [0:ROUNDS-1][47:0]    round_keys,
  input  logic                       decrypt,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [63:0]                text_final_perm,
  output logic                       busy,
  output logic [$clog2(ROUNDS)-1:0]  round_idx
);

  localparam int IW = $clog2(ROUNDS);
  localparam logic [IW-1:0] LAST = IW'(ROUNDS - 1);

  // S1..S8, each row-major (row*16+col), entry 0 in the top nibble
  localparam logic [0:7][255:0] SBOX = {
    256'hE4D12FB83A6C5907_0F74E2D1A6CB9538_41E8D62BFC973A50_FC8249175B3EA06D,
    256'hF18E6B34972DC05A_3D47F28EC01A69B5_0E7BA4D158C6932F_D8A13F42B67C05E9,
    256'hA09E63F51DC7B428_D709346A285ECBF1_D6498F30B12C5AE7_1AD069874FE3B52C,
    256'h7DE3069A1285BC4F_D8B56F03472C1AE9_A690CB7DF13E5284_3F06A1D8945BC72E,
    256'h2C417AB6853FD0E9_EB2C47D150FA3986_421BAD78F9C5630E_B8C71E2D6F09A453,
    256'hC1AF92680D34E75B_AF427C9561DE0B38_9EF528C3704A1DB6_432C95FABE17608D,
    256'h4B2EF08D3C975A61_D0B7491AE35C2F86_14BDC37EAF680592_6BD814A7950FE23C,
    256'hD2846FB1A93E50C7_1FD8A374C56B0E92_7B419CE206ADF358_21E74A8DFC90356B
  };

  localparam int PTAB [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17,
    1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9,
    19, 13, 30, 6, 22, 11, 4, 25
  };

  function automatic logic [31:0] feistel(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          n;
    int          a;
    // Expansion: box i reads a 6-bit window starting one bit
    // before its 4-bit slice, wrapping around the 32-bit half.
    for (int i = 0; i < 8; i++) begin
      for (int m = 0; m < 6; m++) begin
        n = (4 * i + m + 31) % 32;
        x[47-6*i-m] = r[31-n];
      end
    end
    x = x ^ k;
    for (int i = 0; i < 8; i++) begin
      b = x[47-6*i -: 6];
      a = int'({b[5], b[0], b[4:1]});
      s[31-4*i -: 4] = SBOX[i][255-4*a -: 4];
    end
    for (int j = 0; j < 32; j++) begin
      p[31-j] = s[32-PTAB[j]];
    end
    return p;
  endfunction

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_DONE
  } state_t;

  state_t                    r_state;
  state_t                    w_next;
  logic [63:0]               r_data;
  logic [0:ROUNDS-1][47:0]   r_keys;
  logic                      r_mode;
  logic [IW-1:0]             r_idx;
  logic                      w_accept;
  logic                      w_last;
  logic [IW-1:0]             w_kidx;
  logic [47:0]               w_key;
  logic [63:0]               w_round;

  assign w_last  = (r_idx == LAST);
  assign w_kidx  = r_mode ? (LAST - r_idx) : r_idx;
  assign w_key   = r_keys[w_kidx];
  assign w_round = {r_data[31:0],
                    r_data[63:32] ^ feistel(r_data[31:0], w_key)};

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next    = r_state;
    w_accept  = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          w_accept = 1'b1;
          w_next   = S_RUN;
        end
      end
      S_RUN: begin
        busy = 1'b1;
        if (w_last) w_next = S_DONE;
      end
      S_DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
      r_keys <= '0;
      r_mode <= 1'b0;
      r_idx  <= '0;
    end else if (w_accept) begin
      r_data <= init_perm_text;
      r_keys <= round_keys;
      r_mode <= decrypt;
      r_idx  <= '0;
    end else if (r_state == S_RUN) begin
      r_data <= w_round;
      r_idx  <= w_last ? '0 : r_idx + 1'b1;
    end
  end

  // The last round leaves {L,R}; DES hands {R,L} to the final permutation.
  assign text_final_perm = {r_data[31:0], r_data[63:32]};
  assign round_idx       = r_idx;

endmodule

// File: tb/tb_des_round_sequencer.sv
// Scoreboard bench for des_round_sequencer with a full DES reference
// (IP/FP, key schedule, Feistel) and known-answer vectors.
module tb_des_round_sequencer;

  localparam int ROUNDS = 16;
  typedef logic [0:ROUNDS-1][47:0] keys_t;
  typedef struct packed {
    logic [63:0] val;
    logic [31:0] id;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [63:0] init_perm_text = '0;
  keys_t       round_keys = '0;
  logic        decrypt = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [63:0] text_final_perm;
  logic        busy;
  logic [3:0]  round_idx;

  int   n_checks = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   blk_id = 0;
  exp_t exp_q [$];
  exp_t mon_e;

  des_round_sequencer #(.ROUNDS(ROUNDS)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .init_perm_text(init_perm_text),
    .round_keys(round_keys),
    .decrypt(decrypt),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .text_final_perm(text_final_perm),
    .busy(busy),
    .round_idx(round_idx)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  localparam int IP_T [64] = '{
    58, 50, 42, 34, 26, 18, 10, 2, 60, 52, 44, 36, 28, 20, 12, 4,
    62, 54, 46, 38, 30, 22, 14, 6, 64, 56, 48, 40, 32, 24, 16, 8,
    57, 49, 41, 33, 25, 17, 9, 1, 59, 51, 43, 35, 27, 19, 11, 3,
    61, 53, 45, 37, 29, 21, 13, 5, 63, 55, 47, 39, 31, 23, 15, 7};
  localparam int FP_T [64] = '{
    40, 8, 48, 16, 56, 24, 64, 32, 39, 7, 47, 15, 55, 23, 63, 31,
    38, 6, 46, 14, 54, 22, 62, 30, 37, 5, 45, 13, 53, 21, 61, 29,
    36, 4, 44, 12, 52, 20, 60, 28, 35, 3, 43, 11, 51, 19, 59, 27,
    34, 2, 42, 10, 50, 18, 58, 26, 33, 1, 41, 9, 49, 17, 57, 25};
  localparam int PC1_T [56] = '{
    57, 49, 41, 33, 25, 17, 9, 1, 58, 50, 42, 34, 26, 18,
    10, 2, 59, 51, 43, 35, 27, 19, 11, 3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15, 7, 62, 54, 46, 38, 30, 22,
    14, 6, 61, 53, 45, 37, 29, 21, 13, 5, 28, 20, 12, 4};
  localparam int PC2_T [48] = '{
    14, 17, 11, 24, 1, 5, 3, 28, 15, 6, 21, 10,
    23, 19, 12, 4, 26, 8, 16, 7, 27, 20, 13, 2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32};
  localparam int SH_T [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};
  localparam int E_T [48] = '{
    32, 1, 2, 3, 4, 5, 4, 5, 6, 7, 8, 9,
    8, 9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
    16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
    24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32, 1};
  localparam int P_T [32] = '{
    16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
    2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
  // One S-box row per entry (box*4 + row), column 0 in the top nibble
  localparam logic [63:0] SR [32] = '{
    64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538,
    64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D,
    64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5,
    64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9,
    64'hA09E63F51DC7B428, 64'hD709346A285ECBF1,
    64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C,
    64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9,
    64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E,
    64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986,
    64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453,
    64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38,
    64'h9EF528C3704A1DB6, 64'h432C95FABE17608D,
    64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86,
    64'h14BDC37EAF680592, 64'h6BD814A7950FE23C,
    64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92,
    64'h7B419CE206ADF358, 64'h21E74A8DFC90356B};

  function automatic logic [63:0] ip(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-IP_T[i]];
    return y;
  endfunction

  function automatic logic [63:0] fp(input logic [63:0] x);
    logic [63:0] y;
    for (int i = 0; i < 64; i++) y[63-i] = x[64-FP_T[i]];
    return y;
  endfunction

  function automatic keys_t ksched(input logic [63:0] key);
    logic [55:0] cd;
    logic [27:0] c;
    logic [27:0] d;
    keys_t       ks;
    for (int i = 0; i < 56; i++) cd[55-i] = key[64-PC1_T[i]];
    c = cd[55:28];
    d = cd[27:0];
    for (int r = 0; r < 16; r++) begin
      for (int s = 0; s < SH_T[r]; s++) begin
        c = {c[26:0], c[27]};
        d = {d[26:0], d[27]};
      end
      cd = {c, d};
      for (int i = 0; i < 48; i++) ks[r][47-i] = cd[56-PC2_T[i]];
    end
    return ks;
  endfunction

  function automatic logic [31:0] fbox(
    input logic [31:0] r,
    input logic [47:0] k
  );
    logic [47:0] x;
    logic [31:0] s;
    logic [31:0] p;
    logic [5:0]  b;
    int          row;
    int          col;
    for (int i = 0; i < 48; i++) x[47-i] = r[32-E_T[i]];
    x = x ^ k;
    for (int bx = 0; bx < 8; bx++) begin
      b = x[47-6*bx -: 6];
      row = 2 * int'(b[5]) + int'(b[0]);
      col = int'(b[4:1]);
      s[31-4*bx -: 4] = SR[bx*4+row][63-4*col -: 4];
    end
    for (int i = 0; i < 32; i++) p[31-i] = s[32-P_T[i]];
    return p;
  endfunction

  function automatic logic [63:0] golden(
    input logic [63:0] blk,
    input keys_t       ks,
    input logic        dec
  );
    logic [31:0] l;
    logic [31:0] r;
    logic [31:0] t;
    l = blk[63:32];
    r = blk[31:0];
    for (int i = 0; i < 16; i++) begin
      t = r;
      r = l ^ fbox(r, ks[dec ? 15 - i : i]);
      l = t;
    end
    return {r, l};
  endfunction

  task automatic check(
    input string       name,
    input logic [63:0] act,
    input logic [63:0] exp
  );
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every completed output handshake is matched in order.
  always @(negedge clk) begin
    if (!rst && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_output: got %h expected none",
                 text_final_perm);
      end else begin
        mon_e = exp_q.pop_front();
        check($sformatf("block%0d", mon_e.id), fp(text_final_perm),
              mon_e.val);
      end
    end
  end

  task automatic send(
    input  logic [63:0] blk,
    input  keys_t       ks,
    input  logic        dec,
    input  logic [63:0] exp,
    output int          acc
  );
    int g;
    g = 0;
    acc = -1;
    in_valid = 1'b1;
    init_perm_text = blk;
    round_keys = ks;
    decrypt = dec;
    @(negedge clk);
    while (!in_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    if (!in_ready) begin
      check("accept_timeout", {63'd0, in_ready}, 64'd1);
      in_valid = 1'b0;
    end else begin
      @(posedge clk);
      acc = cyc;
      exp_q.push_back('{val: exp, id: blk_id});
      blk_id++;
      #1;
      in_valid = 1'b0;
    end
  endtask

  task automatic drain();
    int g;
    g = 0;
    while ((exp_q.size() != 0 || !in_ready) && g < 400) begin
      @(posedge clk);
      #1;
      g++;
    end
    check("drain", 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    keys_t       kk;
    keys_t       rk;
    logic [63:0] t;
    logic [63:0] blk;
    logic [63:0] held;
    logic        dec;
    int          acc;
    int          prev;
    int          n;

    kk = ksched(64'h133457799BBCDFF1);

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_round_idx", 64'(round_idx), 64'd0);
    check("rst_text", text_final_perm, 64'd0);

    // Known-answer encrypt and latency
    send(ip(64'h0123456789ABCDEF), kk, 1'b0, 64'h85E813540F0AB405, acc);
    n = 0;
    do begin
      @(posedge clk);
      #1;
      n++;
      if (!out_valid && n < 16)
        check("run_round_idx", 64'(round_idx), 64'(n));
    end while (!out_valid && n < 40);
    check("kat_latency", 64'(n), 64'd16);
    drain();

    // Known-answer decrypt
    send(ip(64'h85E813540F0AB405), kk, 1'b1, 64'h0123456789ABCDEF, acc);
    drain();

    // Backpressure in DONE
    out_ready = 1'b0;
    send(ip(64'h0123456789ABCDEF), kk, 1'b0, 64'h85E813540F0AB405, acc);
    n = 0;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    held = ip(64'h85E813540F0AB405);
    for (int i = 0; i < 10; i++) begin
      check("bp_out_valid", {63'd0, out_valid}, 64'd1);
      check("bp_in_ready", {63'd0, in_ready}, 64'd0);
      check("bp_text", text_final_perm, held);
      @(posedge clk);
      #1;
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    check("bp_release_out_valid", {63'd0, out_valid}, 64'd0);
    check("bp_release_in_ready", {63'd0, in_ready}, 64'd1);
    drain();

    // Input isolation: scramble inputs after accept
    blk = {$urandom(), $urandom()};
    for (int r = 0; r < 16; r++) begin
      t = {$urandom(), $urandom()};
      rk[r] = t[47:0];
    end
    send(blk, rk, 1'b1, fp(golden(blk, rk, 1'b1)), acc);
    for (int i = 0; i < 18; i++) begin
      init_perm_text = {$urandom(), $urandom()};
      for (int r = 0; r < 16; r++) begin
        t = {$urandom(), $urandom()};
        round_keys[r] = t[47:0];
      end
      decrypt = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
    end
    drain();

    // Reset at round 7 aborts the block
    send(ip(64'h0123456789ABCDEF), kk, 1'b0, 64'h85E813540F0AB405, acc);
    n = 0;
    while (round_idx != 4'd7 && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("mid_reach_round7", 64'(round_idx), 64'd7);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_round_idx", 64'(round_idx), 64'd0);
    check("mid_rst_busy", {63'd0, busy}, 64'd0);
    send(ip(64'h85E813540F0AB405), kk, 1'b1, 64'h0123456789ABCDEF, acc);
    drain();

    // Back-to-back random blocks, continuous in_valid
    prev = 0;
    for (int b = 0; b < 100; b++) begin
      blk = {$urandom(), $urandom()};
      for (int r = 0; r < 16; r++) begin
        t = {$urandom(), $urandom()};
        rk[r] = t[47:0];
      end
      dec = 1'($urandom_range(0, 1));
      in_valid = 1'b1;
      send(blk, rk, dec, fp(golden(blk, rk, dec)), acc);
      if (b > 0) check("b2b_spacing", 64'(acc - prev), 64'd18);
      prev = acc;
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
